// File: rtl/ntt_alu_pkg.sv
// Shared types and width helpers for the NTT ALU arithmetic blocks.
// The divider and the multiplier both derive their full product width here.
package ntt_alu_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_DONE
  } div_state_e;

  // Full product width of an A x B multiply, which is also the divider's dividend width.
  function automatic int dw_of(input int width_a, input int width_b);
    return width_a + width_b;
  endfunction

endpackage

// File: rtl/int_div_step.sv
// One combinational radix-2 restoring division step.
// Kept separate so an unrolled or pipelined divider can chain copies of it.
module int_div_step #(
  parameter int WIDTHB = 17
) (
  input  logic [WIDTHB-1:0] rem,
  input  logic              next_bit,
  input  logic [WIDTHB-1:0] divisor,
  output logic [WIDTHB-1:0] rem_next,
  output logic              q_bit
);

  logic [WIDTHB:0]   shifted;
  logic [WIDTHB+1:0] diff;
  logic              borrow;
  logic              unused_diff_msb;

  assign shifted = {rem, next_bit};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};
  assign borrow  = diff[WIDTHB+1];
  assign q_bit   = ~borrow;

  // The incoming remainder is below the divisor, so the accepted result always fits in WIDTHB bits.
  assign rem_next        = borrow ? shifted[WIDTHB-1:0] : diff[WIDTHB-1:0];
  assign unused_diff_msb = diff[WIDTHB];

endmodule

// File: rtl/int_div.sv
// Iterative radix-2 restoring unsigned divider with valid/ready on both sides.
// One quotient bit per cycle, MSB first; one division in flight at a time.
module int_div
  import ntt_alu_pkg::*;
#(
  parameter int WIDTHA = 17,
  parameter int WIDTHB = 17,
  localparam int DW    = dw_of(WIDTHA, WIDTHB)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     dividend,
  input  logic [WIDTHB-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     quotient,
  output logic [WIDTHB-1:0] remainder,
  output logic              div_zero
);

  localparam int CW = $clog2(DW);

  div_state_e        state, state_next;
  logic [CW-1:0]     cnt;
  logic [DW-1:0]     q_sr;
  logic [WIDTHB-1:0] rem_r;
  logic [WIDTHB-1:0] divisor_r;
  logic [WIDTHB-1:0] rem_next;
  logic              q_bit;
  logic              accept;

  assign accept = in_valid && in_ready;

  int_div_step #(.WIDTHB(WIDTHB)) u_step (
    .rem      (rem_r),
    .next_bit (q_sr[DW-1]),
    .divisor  (divisor_r),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= state_next;
  end

  // NOTE: the default assignment up front keeps this purely combinational (no latch on unlisted paths).
  always_comb begin
    state_next = state;
    unique case (state)
      DIV_IDLE: if (accept) state_next = (divisor == '0) ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt == '0) state_next = DIV_DONE;
      DIV_DONE: if (out_ready) state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == DIV_IDLE);
    out_valid = (state == DIV_DONE);
  end

  // Result registers load only on completion, so a partial quotient never reaches the ports.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      q_sr      <= '0;
      rem_r     <= '0;
      divisor_r <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (accept) begin
            q_sr      <= dividend;
            divisor_r <= divisor;
            rem_r     <= '0;
            cnt       <= CW'(DW - 1);
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend[WIDTHB-1:0];
              div_zero  <= 1'b1;
            end
          end
        end
        DIV_CALC: begin
          q_sr  <= {q_sr[DW-2:0], q_bit};
          rem_r <= rem_next;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient  <= {q_sr[DW-2:0], q_bit};
            remainder <= rem_next;
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_div.sv
// Directed-vector and randomised self-checking bench for int_div (WIDTHA=WIDTHB=17, DW=34).
// Latency is counted in clock edges from the accept edge up to the edge after which out_valid is high.
module tb_int_div;

  localparam int WA = 17;
  localparam int WB = 17;
  localparam int DW = WA + WB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [WB-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [WB-1:0] remainder;
  logic          div_zero;

  always #5 clk = ~clk;

  int_div #(.WIDTHA(WA), .WIDTHB(WB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [WB-1:0] b;
    logic [DW-1:0] q;
    logic [WB-1:0] r;
    logic          dz;
    int            lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one operation from IDLE, waits for the result, holds it for 'hold' cycles, then retires it.
  task automatic run_op(input logic [DW-1:0] a, input logic [WB-1:0] b, input int hold,
                        output logic [DW-1:0] q, output logic [WB-1:0] r,
                        output logic dz, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_zero;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] q, a, exp_q;
    logic [WB-1:0] r, b, exp_r;
    logic          dz;
    int            lat;

    vecs[0]  = '{34'd100,         17'd7,      34'd14,          17'd2,     1'b0, 35};
    vecs[1]  = '{34'h3_FFFF_FFFF, 17'd1,      34'h3_FFFF_FFFF, 17'd0,     1'b0, 35};
    vecs[2]  = '{34'h3_FFFF_FFFF, 17'h1FFFF,  34'h2_0001,      17'd0,     1'b0, 35};
    vecs[3]  = '{34'h2_0000_1234, 17'd0,      34'h3_FFFF_FFFF, 17'h1234,  1'b1, 1};
    vecs[4]  = '{34'd0,           17'd5,      34'd0,           17'd0,     1'b0, 35};
    vecs[5]  = '{34'd1000,        17'd1000,   34'd1,           17'd0,     1'b0, 35};
    vecs[6]  = '{34'd999,         17'd1000,   34'd0,           17'd999,   1'b0, 35};
    vecs[7]  = '{34'h2_0000_0000, 17'd2,      34'h1_0000_0000, 17'd0,     1'b0, 35};
    vecs[8]  = '{34'h3_FFFF_FFFF, 17'h10000,  34'h3_FFFF,      17'hFFFF,  1'b0, 35};
    vecs[9]  = '{34'd5,           17'd0,      34'h3_FFFF_FFFF, 17'd5,     1'b1, 1};
    vecs[10] = '{34'd131070,      17'h1FFFF,  34'd0,           17'd131070, 1'b0, 35};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("reset_in_ready",  in_ready,  1);
    check("reset_out_valid", out_valid, 0);
    check("reset_quotient",  quotient,  0);
    check("reset_remainder", remainder, 0);
    check("reset_div_zero",  div_zero,  0);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, i % 3, q, r, dz, lat);
      check($sformatf("vec%0d_q", i),   q,   vecs[i].q);
      check($sformatf("vec%0d_r", i),   r,   vecs[i].r);
      check($sformatf("vec%0d_dz", i),  dz,  vecs[i].dz);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // Back-pressure: 5/3 held for 10 cycles while a second request knocks on the input.
    dividend = 34'd5;
    divisor  = 17'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", lat, 35);
    dividend = 34'd7;
    divisor  = 17'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_q",         quotient,  1);
      check("bp_r",         remainder, 2);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready",  in_ready,  0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_in_ready", in_ready, 1);
    repeat (40) @(negedge clk);
    check("bp_no_second_op", out_valid, 0);

    // Reset at iteration 20 of a division abandons it.
    dividend = 34'd100000;
    divisor  = 17'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready",  in_ready,  1);
    check("rst_mid_quotient",  quotient,  0);
    check("rst_mid_remainder", remainder, 0);
    check("rst_mid_div_zero",  div_zero,  0);
    run_op(34'd9, 17'd4, 0, q, r, dz, lat);
    check("after_rst_q",   q,   2);
    check("after_rst_r",   r,   1);
    check("after_rst_lat", lat, 35);

    // Randomised back-to-back operations against the language's own / and %.
    for (int i = 0; i < 250; i++) begin
      a = DW'({$urandom, $urandom});
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = WB'($urandom_range(1, 15));
        default: b = WB'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) a = DW'($urandom_range(0, 200000));
      if (b == '0) begin
        exp_q = '1;
        exp_r = a[WB-1:0];
      end else begin
        exp_q = a / DW'(b);
        exp_r = WB'(a % DW'(b));
      end
      run_op(a, b, $urandom_range(0, 3), q, r, dz, lat);
      check($sformatf("rand%0d_qr", i), {q, r}, {exp_q, exp_r});
      check($sformatf("rand%0d_lat", i), lat, (b == '0) ? 1 : 35);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
